// File: rtl/mbox_req_seq.sv
// EBOX-to-memory request sequencer: read, write and read-pause-write cycles on a
// request/acknowledge memory port, with a no-response (NXM) timeout.
module mbox_req_seq #(
    parameter int NXM_TIMEOUT = 64,
    parameter int TIMER_W     = 7
) (
    input  logic         mboxClk,
    input  logic         eboxReset,
    input  logic         EBOX_REQ,
    input  logic [13:35] EBOX_VMA,
    input  logic         eboxRead,
    input  logic         eboxWrite,
    input  logic         eboxPSE,
    input  logic [0:35]  cacheDataWrite,
    input  logic         nxmClr,
    output logic         memReq,
    output logic [13:35] memAdr,
    output logic         memWr,
    output logic [0:35]  memWrData,
    input  logic         memAck,
    input  logic [0:35]  memRdData,
    output logic [0:35]  cacheDataRead,
    output logic         cshEBOXT0,
    output logic         cshEBOXRetry,
    output logic         mboxRespIn,
    output logic         nxmErr,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t               r_state;
    logic [13:35]         r_adr;
    logic [0:35]          r_wrData;
    logic                 r_pse;
    logic [TIMER_W-1:0]   r_timer;
    logic [0:35]          r_rdData;
    logic                 r_t0;
    logic                 r_resp;
    logic                 r_nxm;

    state_t               w_stateNxt;
    logic [13:35]         w_adrNxt;
    logic [0:35]          w_wrDataNxt;
    logic                 w_pseNxt;
    logic [TIMER_W-1:0]   w_timerNxt;
    logic [0:35]          w_rdDataNxt;
    logic                 w_t0Nxt;
    logic                 w_respNxt;
    logic                 w_nxmSet;
    logic                 w_retry;
    logic                 w_expired;

    // Expiry only matters when memAck is absent; a same-cycle ack completes normally.
    assign w_expired = (r_timer == TIMER_W'(NXM_TIMEOUT - 1)) && !memAck;

    always_comb begin
        w_stateNxt  = r_state;
        w_adrNxt    = r_adr;
        w_wrDataNxt = r_wrData;
        w_pseNxt    = r_pse;
        w_timerNxt  = r_timer;
        w_rdDataNxt = r_rdData;
        w_t0Nxt     = 1'b0;
        w_respNxt   = 1'b0;
        w_nxmSet    = 1'b0;
        w_retry     = 1'b0;
        case (r_state)
            IDLE: begin
                if (EBOX_REQ && (eboxRead || eboxWrite)) begin
                    w_adrNxt    = EBOX_VMA;
                    w_wrDataNxt = cacheDataWrite;
                    w_pseNxt    = eboxRead && eboxPSE;
                    w_timerNxt  = '0;
                    w_t0Nxt     = 1'b1;
                    w_stateNxt  = eboxRead ? RD : WR;
                end
            end
            RD: begin
                w_retry = EBOX_REQ;
                if (memAck) begin
                    w_rdDataNxt = memRdData;
                    w_respNxt   = 1'b1;
                    w_stateNxt  = r_pse ? PAUSE : IDLE;
                end else if (w_expired) begin
                    w_rdDataNxt = '0;
                    w_respNxt   = 1'b1;
                    w_nxmSet    = 1'b1;
                    w_pseNxt    = 1'b0;
                    w_stateNxt  = IDLE;
                end else begin
                    w_timerNxt = r_timer + 1'b1;
                end
            end
            WR: begin
                w_retry = EBOX_REQ;
                if (memAck) begin
                    w_respNxt  = 1'b1;
                    w_stateNxt = IDLE;
                end else if (w_expired) begin
                    w_respNxt  = 1'b1;
                    w_nxmSet   = 1'b1;
                    w_stateNxt = IDLE;
                end else begin
                    w_timerNxt = r_timer + 1'b1;
                end
            end
            PAUSE: begin
                // Write half of a PSE cycle keeps the address latched by the read half.
                if (EBOX_REQ) begin
                    if (eboxWrite) begin
                        w_wrDataNxt = cacheDataWrite;
                        w_pseNxt    = 1'b0;
                        w_timerNxt  = '0;
                        w_t0Nxt     = 1'b1;
                        w_stateNxt  = WR;
                    end else begin
                        w_retry = 1'b1;
                    end
                end
            end
            default: w_stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge mboxClk or posedge eboxReset) begin
        if (eboxReset) begin
            r_state  <= IDLE;
            r_adr    <= '0;
            r_wrData <= '0;
            r_pse    <= 1'b0;
            r_timer  <= '0;
            r_rdData <= '0;
            r_t0     <= 1'b0;
            r_resp   <= 1'b0;
            r_nxm    <= 1'b0;
        end else begin
            r_state  <= w_stateNxt;
            r_adr    <= w_adrNxt;
            r_wrData <= w_wrDataNxt;
            r_pse    <= w_pseNxt;
            r_timer  <= w_timerNxt;
            r_rdData <= w_rdDataNxt;
            r_t0     <= w_t0Nxt;
            r_resp   <= w_respNxt;
            if (w_nxmSet) begin
                r_nxm <= 1'b1;
            end else if (nxmClr) begin
                r_nxm <= 1'b0;
            end
        end
    end

    assign memReq        = (r_state == RD) || (r_state == WR);
    assign memWr         = (r_state == WR);
    assign memAdr        = r_adr;
    assign memWrData     = r_wrData;
    assign cacheDataRead = r_rdData;
    assign cshEBOXT0     = r_t0;
    assign cshEBOXRetry  = w_retry;
    assign mboxRespIn    = r_resp;
    assign nxmErr        = r_nxm;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_mbox_req_seq.sv
// Randomized scoreboard bench for mbox_req_seq: a driver pushes expected memory phases and
// EBOX responses, a memory responder and a response monitor pop and compare them.
module tb_mbox_req_seq;

    localparam int NXM_TIMEOUT = 64;
    localparam int TIMER_W     = 7;
    localparam int RESP_LIMIT  = 300;
    localparam int NO_ACK      = 1000;

    logic         mboxClk = 1'b0;
    logic         eboxReset;
    logic         EBOX_REQ;
    logic [13:35] EBOX_VMA;
    logic         eboxRead;
    logic         eboxWrite;
    logic         eboxPSE;
    logic [0:35]  cacheDataWrite;
    logic         nxmClr;
    logic         memReq;
    logic [13:35] memAdr;
    logic         memWr;
    logic [0:35]  memWrData;
    logic         memAck;
    logic [0:35]  memRdData;
    logic [0:35]  cacheDataRead;
    logic         cshEBOXT0;
    logic         cshEBOXRetry;
    logic         mboxRespIn;
    logic         nxmErr;
    logic         busy;

    mbox_req_seq #(
        .NXM_TIMEOUT(NXM_TIMEOUT),
        .TIMER_W    (TIMER_W)
    ) dut (
        .mboxClk       (mboxClk),
        .eboxReset     (eboxReset),
        .EBOX_REQ      (EBOX_REQ),
        .EBOX_VMA      (EBOX_VMA),
        .eboxRead      (eboxRead),
        .eboxWrite     (eboxWrite),
        .eboxPSE       (eboxPSE),
        .cacheDataWrite(cacheDataWrite),
        .nxmClr        (nxmClr),
        .memReq        (memReq),
        .memAdr        (memAdr),
        .memWr         (memWr),
        .memWrData     (memWrData),
        .memAck        (memAck),
        .memRdData     (memRdData),
        .cacheDataRead (cacheDataRead),
        .cshEBOXT0     (cshEBOXT0),
        .cshEBOXRetry  (cshEBOXRetry),
        .mboxRespIn    (mboxRespIn),
        .nxmErr        (nxmErr),
        .busy          (busy)
    );

    always #5 mboxClk = ~mboxClk;

    typedef struct {
        logic [0:35] rdData;
        logic        nxm;
    } resp_t;

    typedef struct {
        logic         wr;
        logic [13:35] adr;
        logic [0:35]  data;
    } phase_t;

    resp_t       respQ[$];
    phase_t      phaseQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cycleCount = 0;
    logic [0:35] modelLastRead = '0;
    logic        modelNxm = 1'b0;
    int          ackDelay = 0;
    bit          noAck = 1'b0;
    bit          spurReq = 1'b0;
    bit          useFixedData = 1'b0;
    logic [0:35] fixedData = '0;

    always @(posedge mboxClk) cycleCount <= cycleCount + 1;

    // Memory contents are an address-derived pattern unless a directed test pins the word.
    function automatic logic [0:35] memWord(input logic [13:35] a);
        if (useFixedData) return fixedData;
        return 36'(a) ^ 36'o525252525252;
    endfunction

    task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cycleCount);
        end
    endtask

    // Memory responder: checks each new phase against the scoreboard and acks after ackDelay.
    initial begin
        int     waitCnt;
        phase_t p;
        waitCnt   = 0;
        memAck    = 1'b0;
        memRdData = '0;
        p.wr = 1'b0; p.adr = '0; p.data = '0;
        forever begin
            @(negedge mboxClk);
            if (memAck) begin
                memAck  = 1'b0;
                waitCnt = 0;
            end else if (memReq) begin
                if (waitCnt == 0) begin
                    if (phaseQ.size() == 0) begin
                        checkOutput("unexpectedMemReq", 36'(memReq), 36'(0));
                    end else begin
                        p = phaseQ.pop_front();
                        checkOutput("phaseMemWr", 36'(memWr), 36'(p.wr));
                        checkOutput("phaseMemAdr", 36'(memAdr), 36'(p.adr));
                        checkOutput("phaseMemWrData", memWrData, p.data);
                    end
                end
                if (!noAck && waitCnt == ackDelay) begin
                    checkOutput("ackMemAdrStable", 36'(memAdr), 36'(p.adr));
                    checkOutput("ackMemWrDataStable", memWrData, p.data);
                    memAck    = 1'b1;
                    memRdData = memWord(memAdr);
                end
                waitCnt++;
            end else begin
                waitCnt = 0;
                if (spurReq) begin
                    memAck    = 1'b1;
                    memRdData = 36'o707070707070;
                    spurReq   = 1'b0;
                end
            end
        end
    end

    // Response monitor: every mboxRespIn pulse must match the oldest expected response.
    initial begin
        resp_t e;
        forever begin
            @(negedge mboxClk);
            if (mboxRespIn) begin
                if (respQ.size() == 0) begin
                    checkOutput("unexpectedRespIn", 36'(mboxRespIn), 36'(0));
                end else begin
                    e = respQ.pop_front();
                    checkOutput("respCacheDataRead", cacheDataRead, e.rdData);
                    checkOutput("respNxmErr", 36'(nxmErr), 36'(e.nxm));
                end
            end
        end
    end

    task automatic waitResp(input int expCycle, input string name);
        int n;
        n = 0;
        while (!mboxRespIn && n < RESP_LIMIT) begin
            @(negedge mboxClk);
            n++;
        end
        if (!mboxRespIn) checkOutput({name, "Timeout"}, 36'(0), 36'(1));
        else checkOutput({name, "Latency"}, 36'(cycleCount), 36'(expCycle));
    endtask

    task automatic applyStimulus(input bit doRead, input bit doWrite, input bit doPse,
                                 input logic [13:35] vma, input logic [0:35] wd, input logic [0:35] wd2,
                                 input int delay1, input int delay2, input int pauseCycles,
                                 input bit retryRd, input bit retryPause);
        int     c0;
        bit     nxm1;
        phase_t p;
        resp_t  r;
        nxm1   = (delay1 >= NXM_TIMEOUT);
        p.wr   = !doRead;
        p.adr  = vma;
        p.data = wd;
        phaseQ.push_back(p);
        if (doRead) modelLastRead = nxm1 ? 36'(0) : memWord(vma);
        modelNxm = modelNxm | nxm1;
        r.rdData = modelLastRead;
        r.nxm    = modelNxm;
        respQ.push_back(r);
        ackDelay = delay1;
        noAck    = nxm1;
        c0 = cycleCount;
        EBOX_REQ = 1'b1; eboxRead = doRead; eboxWrite = doWrite; eboxPSE = doPse;
        EBOX_VMA = vma; cacheDataWrite = wd;
        @(negedge mboxClk);
        EBOX_REQ = 1'b0;
        EBOX_VMA = 23'($urandom());
        cacheDataWrite = 36'({$urandom(), $urandom()});
        checkOutput("t0Pulse", 36'(cshEBOXT0), 36'(1));
        checkOutput("memReqRise", 36'(memReq), 36'(1));
        if (retryRd) begin
            EBOX_REQ = 1'b1; eboxRead = 1'($urandom()); eboxWrite = 1'($urandom()); eboxPSE = 1'($urandom());
            #1;
            checkOutput("retryDuringPhase", 36'(cshEBOXRetry), 36'(1));
            @(negedge mboxClk);
            EBOX_REQ = 1'b0;
            checkOutput("noT0AfterRetry", 36'(cshEBOXT0), 36'(0));
        end
        waitResp(nxm1 ? c0 + NXM_TIMEOUT + 1 : c0 + delay1 + 2, "phase1");
        if (doRead && doPse && !nxm1) begin
            for (int i = 0; i < pauseCycles; i++) begin
                checkOutput("pauseBusy", 36'(busy), 36'(1));
                checkOutput("pauseMemReq", 36'(memReq), 36'(0));
                @(negedge mboxClk);
            end
            if (retryPause) begin
                EBOX_REQ = 1'b1; eboxRead = 1'b1; eboxWrite = 1'b0;
                #1;
                checkOutput("retryInPause", 36'(cshEBOXRetry), 36'(1));
                @(negedge mboxClk);
                EBOX_REQ = 1'b0;
                checkOutput("pauseNoT0", 36'(cshEBOXT0), 36'(0));
                checkOutput("pauseStillBusy", 36'(busy), 36'(1));
            end
            p.wr   = 1'b1;
            p.adr  = vma;
            p.data = wd2;
            phaseQ.push_back(p);
            r.rdData = modelLastRead;
            r.nxm    = modelNxm;
            respQ.push_back(r);
            ackDelay = delay2;
            noAck    = 1'b0;
            c0 = cycleCount;
            EBOX_REQ = 1'b1; eboxWrite = 1'b1; eboxRead = 1'($urandom()); eboxPSE = 1'($urandom());
            EBOX_VMA = 23'($urandom()); cacheDataWrite = wd2;
            @(negedge mboxClk);
            EBOX_REQ = 1'b0;
            checkOutput("pseT0Pulse", 36'(cshEBOXT0), 36'(1));
            checkOutput("pseMemWr", 36'(memWr), 36'(1));
            waitResp(c0 + delay2 + 2, "phase2");
        end
        checkOutput("idleAfterTxn", 36'(busy), 36'(0));
    endtask

    task automatic clearNxm();
        nxmClr = 1'b1;
        @(negedge mboxClk);
        nxmClr   = 1'b0;
        modelNxm = 1'b0;
        checkOutput("nxmCleared", 36'(nxmErr), 36'(0));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          kind;
        bit          rd;
        bit          wr;
        bit          pse;
        int          d1;
        logic [0:35] held;
        eboxReset = 1'b1;
        EBOX_REQ = 1'b0; EBOX_VMA = '0; eboxRead = 1'b0; eboxWrite = 1'b0; eboxPSE = 1'b0;
        cacheDataWrite = '0; nxmClr = 1'b0;
        repeat (3) @(negedge mboxClk);
        checkOutput("resetMemReq", 36'(memReq), 36'(0));
        checkOutput("resetBusy", 36'(busy), 36'(0));
        checkOutput("resetNxmErr", 36'(nxmErr), 36'(0));
        checkOutput("resetCacheDataRead", cacheDataRead, 36'(0));
        checkOutput("resetT0", 36'(cshEBOXT0), 36'(0));
        checkOutput("resetRespIn", 36'(mboxRespIn), 36'(0));
        checkOutput("resetMemAdr", 36'(memAdr), 36'(0));
        eboxReset = 1'b0;
        @(negedge mboxClk);

        $display("[TB] request with neither read nor write is ignored");
        EBOX_REQ = 1'b1; EBOX_VMA = 23'h000777;
        #1;
        checkOutput("ignoredNoRetry", 36'(cshEBOXRetry), 36'(0));
        @(negedge mboxClk);
        EBOX_REQ = 1'b0;
        checkOutput("ignoredNoT0", 36'(cshEBOXT0), 36'(0));
        checkOutput("ignoredNotBusy", 36'(busy), 36'(0));

        $display("[TB] directed read, write, PSE, retry");
        useFixedData = 1'b1;
        fixedData    = 36'o123456701234;
        applyStimulus(1, 0, 0, 23'h001234, 36'o0, 36'o0, 3, 0, 0, 0, 0);
        useFixedData = 1'b0;
        applyStimulus(0, 1, 0, 23'h054321, 36'o777777000000, 36'o0, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 23'h02aaaa, 36'o111111111111, 36'o0, 2, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 23'h013579, 36'o222222222222, 36'o333333333333, 2, 1, 5, 1, 1);

        $display("[TB] NXM on read, ack exactly at expiry, NXM with concurrent clear");
        applyStimulus(1, 0, 0, 23'h070707, 36'o0, 36'o0, NO_ACK, 0, 0, 0, 0);
        clearNxm();
        applyStimulus(1, 0, 1, 23'h012345, 36'o444444444444, 36'o555555555555, NO_ACK, 0, 0, 0, 0);
        clearNxm();
        applyStimulus(1, 0, 0, 23'h046464, 36'o0, 36'o0, NXM_TIMEOUT - 1, 0, 0, 0, 0);
        nxmClr = 1'b1;
        applyStimulus(0, 1, 0, 23'h011111, 36'o666666666666, 36'o0, NO_ACK, 0, 0, 0, 0);
        @(negedge mboxClk);
        nxmClr   = 1'b0;
        modelNxm = 1'b0;
        checkOutput("nxmClrAfterSetWin", 36'(nxmErr), 36'(0));

        $display("[TB] spurious memAck in idle");
        held = modelLastRead;
        spurReq = 1'b1;
        repeat (3) @(negedge mboxClk);
        checkOutput("spuriousAckNotBusy", 36'(busy), 36'(0));
        checkOutput("spuriousAckDataHeld", cacheDataRead, held);

        $display("[TB] reset in the middle of a write");
        applyStimulus(1, 0, 0, 23'h003003, 36'o0, 36'o0, NO_ACK, 0, 0, 0, 0);
        begin
            phase_t p;
            p.wr = 1'b1; p.adr = 23'h055055; p.data = 36'o123123123123;
            phaseQ.push_back(p);
        end
        ackDelay = 20;
        noAck    = 1'b0;
        EBOX_REQ = 1'b1; eboxRead = 1'b0; eboxWrite = 1'b1; eboxPSE = 1'b0;
        EBOX_VMA = 23'h055055; cacheDataWrite = 36'o123123123123;
        @(negedge mboxClk);
        EBOX_REQ = 1'b0;
        checkOutput("preResetMemReq", 36'(memReq), 36'(1));
        repeat (3) @(negedge mboxClk);
        #2;
        eboxReset = 1'b1;
        #1;
        checkOutput("asyncResetMemReq", 36'(memReq), 36'(0));
        checkOutput("asyncResetBusy", 36'(busy), 36'(0));
        checkOutput("asyncResetNxmErr", 36'(nxmErr), 36'(0));
        checkOutput("asyncResetCacheDataRead", cacheDataRead, 36'(0));
        modelNxm      = 1'b0;
        modelLastRead = '0;
        @(negedge mboxClk);
        eboxReset = 1'b0;
        applyStimulus(1, 0, 0, 23'h066066, 36'o0, 36'o0, 2, 0, 0, 0, 0);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 3);
            rd   = (kind != 1);
            wr   = (kind == 1) || (kind == 2) || ((kind == 3) && 1'($urandom()));
            pse  = (kind == 3) || ((kind == 1) && 1'($urandom()));
            d1   = ($urandom_range(0, 9) == 0) ? NO_ACK : $urandom_range(0, 6);
            applyStimulus(rd, wr, pse, 23'($urandom()), 36'({$urandom(), $urandom()}),
                          36'({$urandom(), $urandom()}), d1, $urandom_range(0, 6),
                          $urandom_range(0, 4), 1'($urandom()), 1'($urandom()));
            if (modelNxm && 1'($urandom())) clearNxm();
            repeat ($urandom_range(0, 2)) @(negedge mboxClk);
        end

        repeat (5) @(negedge mboxClk);
        checkOutput("respQueueDrained", 36'(respQ.size()), 36'(0));
        checkOutput("phaseQueueDrained", 36'(phaseQ.size()), 36'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
